// File: rtl/csr_trap_unit_pkg.sv
// Shared machine-mode CSR definitions: addresses, field positions, cause codes
// and constant read values. Decode imports the same package.
package csr_trap_unit_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_MHARTID   = 12'hF14
    } csr_addr_e;

    // Field positions inside mstatus / mie / mip.
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIE_MEIE_BIT     = 11;
    localparam int unsigned MIP_MEIP_BIT     = 11;

    // MPP is hardwired to machine mode (2'b11 in bits 12:11).
    localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
    localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

    // Word alignment mask for mtvec and mepc.
    localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

    // Trap cause codes.
    localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;
    localparam logic [31:0] CAUSE_MEI          = 32'h8000_000B;

    // Read-only CSRs: software writes are dropped and flagged illegal.
    function automatic logic csr_is_readonly(input logic [11:0] addr);
        return (addr == CSR_MISA) || (addr == CSR_MIP) || (addr == CSR_MHARTID);
    endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit performance counter with increment enable and independent low/high
// word write ports. A write to either half takes precedence over the
// increment for that cycle; the carry out of the low word feeds the high word.
module csr_trap_unit_counter64 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_data_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // Next count: software write replaces a half, otherwise optionally increment.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_d[31:0]  = wr_data_i;
            if (wr_hi_i) count_d[63:32] = wr_data_i;
        end else if (inc_i) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the single-cycle RV32I core.
// Reads, the illegal-access flag and the trap / mret redirects are
// combinational; all CSR state commits at the clock edge.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    input  logic        csr_en_i,
    input  logic [11:0] csr_addr_i,
    input  logic        csr_wr_i,
    input  logic [31:0] csr_wr_data_i,
    input  logic        exception_i,
    input  logic [30:0] exc_code_i,
    input  logic        mret_i,
    input  logic        interrupt_i,
    input  logic        inst_retired_i,
    output logic [31:0] csr_rd_data_o,
    output logic        illegal_csr_o,
    output logic        trap_taken_o,
    output logic [31:0] trap_vector_o,
    output logic [31:0] mret_target_o
);

    // Architectural state.
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q,     mie_meie_d;
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:0] mscratch_q,     mscratch_d;
    logic [31:0] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;

    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic        csr_mapped;
    logic        csr_readonly;
    logic [31:0] csr_rd_data;
    logic [31:0] mstatus_rd;
    logic        irq_take;
    logic        trap_taken;
    logic        csr_commit;

    // Trap decision: exceptions always win, interrupts only when globally and locally enabled.
    assign irq_take   = interrupt_i & mstatus_mie_q & mie_meie_q & ~exception_i;
    assign trap_taken = exception_i | irq_take;

    assign csr_readonly = csr_is_readonly(csr_addr_i);

    // A software write lands only when nothing of higher priority owns the cycle.
    assign csr_commit = csr_wr_i & csr_mapped & ~csr_readonly & ~trap_taken & ~mret_i;

    // Address decode and read mux.
    always_comb begin
        mstatus_rd                   = MSTATUS_MPP_M;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;

        csr_mapped  = 1'b1;
        csr_rd_data = '0;
        case (csr_addr_i)
            CSR_MSTATUS:   csr_rd_data = mstatus_rd;
            CSR_MISA:      csr_rd_data = MISA_VALUE;
            CSR_MIE:       csr_rd_data[MIE_MEIE_BIT] = mie_meie_q;
            CSR_MTVEC:     csr_rd_data = mtvec_q;
            CSR_MSCRATCH:  csr_rd_data = mscratch_q;
            CSR_MEPC:      csr_rd_data = mepc_q;
            CSR_MCAUSE:    csr_rd_data = mcause_q;
            CSR_MIP:       csr_rd_data[MIP_MEIP_BIT] = interrupt_i;
            CSR_MCYCLE:    csr_rd_data = mcycle[31:0];
            CSR_MCYCLEH:   csr_rd_data = mcycle[63:32];
            CSR_MINSTRET:  csr_rd_data = minstret[31:0];
            CSR_MINSTRETH: csr_rd_data = minstret[63:32];
            CSR_MHARTID:   csr_rd_data = '0;
            default:       csr_mapped  = 1'b0;
        endcase
    end

    // Next-state for the non-counter CSRs: trap > mret > software write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        if (trap_taken) begin
            mepc_d         = pc_i & ALIGN4_MASK;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mcause_d       = exception_i ? {1'b0, exc_code_i} : CAUSE_MEI;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_commit) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wr_data_i[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = csr_wr_data_i[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_meie_d = csr_wr_data_i[MIE_MEIE_BIT];
                CSR_MTVEC:    mtvec_d    = csr_wr_data_i & ALIGN4_MASK;
                CSR_MSCRATCH: mscratch_d = csr_wr_data_i;
                CSR_MEPC:     mepc_d     = csr_wr_data_i & ALIGN4_MASK;
                CSR_MCAUSE:   mcause_d   = csr_wr_data_i;
                default: ;
            endcase
        end
    end

    // CSR state registers; reset overrides any trap or write in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET & ALIGN4_MASK;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    csr_trap_unit_counter64 u_mcycle (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .inc_i     (1'b1),
        .wr_lo_i   (csr_commit && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi_i   (csr_commit && (csr_addr_i == CSR_MCYCLEH)),
        .wr_data_i (csr_wr_data_i),
        .count_o   (mcycle)
    );

    csr_trap_unit_counter64 u_minstret (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .inc_i     (inst_retired_i & ~trap_taken),
        .wr_lo_i   (csr_commit && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi_i   (csr_commit && (csr_addr_i == CSR_MINSTRETH)),
        .wr_data_i (csr_wr_data_i),
        .count_o   (minstret)
    );

    assign csr_rd_data_o = csr_rd_data;
    assign illegal_csr_o = (csr_en_i & ~csr_mapped) | (csr_wr_i & csr_readonly);
    assign trap_taken_o  = trap_taken;
    assign trap_vector_o = mtvec_q;
    assign mret_target_o = mepc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed testbench for csr_trap_unit. Inputs change 1 time unit after the
// rising edge; outputs are compared before the next edge.
module tb_csr_trap_unit;

    localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_2003;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic        csr_wr;
    logic [31:0] csr_wr_data;
    logic        exception;
    logic [30:0] exc_code;
    logic        mret;
    logic        interrupt;
    logic        inst_retired;
    logic [31:0] csr_rd_data;
    logic        illegal_csr;
    logic        trap_taken;
    logic [31:0] trap_vector;
    logic [31:0] mret_target;

    int checks   = 0;
    int failures = 0;

    csr_trap_unit #(.MTVEC_RESET(TB_MTVEC_RESET)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .pc_i           (pc),
        .csr_en_i       (csr_en),
        .csr_addr_i     (csr_addr),
        .csr_wr_i       (csr_wr),
        .csr_wr_data_i  (csr_wr_data),
        .exception_i    (exception),
        .exc_code_i     (exc_code),
        .mret_i         (mret),
        .interrupt_i    (interrupt),
        .inst_retired_i (inst_retired),
        .csr_rd_data_o  (csr_rd_data),
        .illegal_csr_o  (illegal_csr),
        .trap_taken_o   (trap_taken),
        .trap_vector_o  (trap_vector),
        .mret_target_o  (mret_target)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset        = 1'b0;
        pc           = '0;
        csr_en       = 1'b0;
        csr_addr     = '0;
        csr_wr       = 1'b0;
        csr_wr_data  = '0;
        exception    = 1'b0;
        exc_code     = '0;
        mret         = 1'b0;
        interrupt    = 1'b0;
        inst_retired = 1'b0;
    endtask

    // One CSRRW-style write committed at the next edge.
    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_en      = 1'b1;
        csr_wr      = 1'b1;
        csr_addr    = addr;
        csr_wr_data = data;
        tick();
        csr_en      = 1'b0;
        csr_wr      = 1'b0;
    endtask

    // Point the read port at an address and let it settle (no clock edge).
    task automatic read_at(input logic [11:0] addr);
        csr_addr = addr;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        read_at(12'h300);
        checks++;
        if (csr_rd_data !== 32'h0000_1800) begin
            failures++; $display("FAIL reset_mstatus got=%h exp=%h", csr_rd_data, 32'h0000_1800);
        end
        read_at(12'h305);
        checks++;
        if (csr_rd_data !== 32'h0000_2000) begin
            failures++; $display("FAIL reset_mtvec got=%h exp=%h", csr_rd_data, 32'h0000_2000);
        end
        read_at(12'hB00);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL reset_mcycle got=%h exp=%h", csr_rd_data, 32'd0);
        end
        checks++;
        if (trap_taken !== 1'b0 || mret_target !== 32'd0) begin
            failures++; $display("FAIL reset_outputs got trap=%b mepc=%h exp trap=0 mepc=0", trap_taken, mret_target);
        end
        tick();
        checks++;
        if (csr_rd_data !== 32'd1) begin
            failures++; $display("FAIL mcycle_after_one got=%h exp=%h", csr_rd_data, 32'd1);
        end
    endtask

    task automatic test_interrupt_trap();
        csr_write(12'h305, 32'h0000_0100);
        csr_write(12'h304, 32'h0000_0800);
        csr_write(12'h300, 32'h0000_0008);
        pc           = 32'h40;
        interrupt    = 1'b1;
        inst_retired = 1'b1;
        #1;
        checks++;
        if (trap_taken !== 1'b1 || trap_vector !== 32'h100) begin
            failures++; $display("FAIL irq_trap got trap=%b vec=%h exp trap=1 vec=00000100", trap_taken, trap_vector);
        end
        tick();
        inst_retired = 1'b0;
        read_at(12'h341);
        checks++;
        if (csr_rd_data !== 32'h40) begin
            failures++; $display("FAIL irq_mepc got=%h exp=%h", csr_rd_data, 32'h40);
        end
        read_at(12'h342);
        checks++;
        if (csr_rd_data !== 32'h8000_000B) begin
            failures++; $display("FAIL irq_mcause got=%h exp=%h", csr_rd_data, 32'h8000_000B);
        end
        read_at(12'h300);
        checks++;
        if (csr_rd_data !== 32'h0000_1880) begin
            failures++; $display("FAIL irq_mstatus got=%h exp=%h", csr_rd_data, 32'h0000_1880);
        end
        read_at(12'hB02);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL irq_minstret got=%h exp=%h", csr_rd_data, 32'd0);
        end
    endtask

    // Interrupt stays asserted after the trap: MIE is clear, so no re-entry.
    task automatic test_back_to_back();
        pc = 32'h100;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (trap_taken !== 1'b0) begin
                failures++; $display("FAIL irq_reentry cycle=%0d got=%b exp=0", i, trap_taken);
            end
            tick();
        end
        checks++;
        if (mret_target !== 32'h40) begin
            failures++; $display("FAIL irq_mepc_held got=%h exp=%h", mret_target, 32'h40);
        end
        interrupt = 1'b0;
    endtask

    task automatic test_mret();
        mret = 1'b1;
        #1;
        checks++;
        if (mret_target !== 32'h40 || trap_taken !== 1'b0) begin
            failures++; $display("FAIL mret_target got=%h trap=%b exp=00000040 trap=0", mret_target, trap_taken);
        end
        tick();
        mret = 1'b0;
        read_at(12'h300);
        checks++;
        if (csr_rd_data !== 32'h0000_1888) begin
            failures++; $display("FAIL mret_mstatus got=%h exp=%h", csr_rd_data, 32'h0000_1888);
        end
    endtask

    task automatic test_exception();
        csr_write(12'h340, 32'h1234_5678);
        pc           = 32'h80;
        exception    = 1'b1;
        exc_code     = 31'd3;
        csr_en       = 1'b1;
        csr_wr       = 1'b1;
        csr_addr     = 12'h340;
        csr_wr_data  = 32'hDEAD_BEEF;
        inst_retired = 1'b1;
        #1;
        checks++;
        if (trap_taken !== 1'b1) begin
            failures++; $display("FAIL exc_trap got=%b exp=1", trap_taken);
        end
        tick();
        exception    = 1'b0;
        csr_en       = 1'b0;
        csr_wr       = 1'b0;
        inst_retired = 1'b0;
        read_at(12'h340);
        checks++;
        if (csr_rd_data !== 32'h1234_5678) begin
            failures++; $display("FAIL exc_mscratch got=%h exp=%h", csr_rd_data, 32'h1234_5678);
        end
        read_at(12'h341);
        checks++;
        if (csr_rd_data !== 32'h80) begin
            failures++; $display("FAIL exc_mepc got=%h exp=%h", csr_rd_data, 32'h80);
        end
        read_at(12'h342);
        checks++;
        if (csr_rd_data !== 32'd3) begin
            failures++; $display("FAIL exc_mcause got=%h exp=%h", csr_rd_data, 32'd3);
        end
        read_at(12'hB02);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL exc_minstret got=%h exp=%h", csr_rd_data, 32'd0);
        end
        read_at(12'h300);
        checks++;
        if (csr_rd_data !== 32'h0000_1880) begin
            failures++; $display("FAIL exc_mstatus got=%h exp=%h", csr_rd_data, 32'h0000_1880);
        end
        inst_retired = 1'b1;
        tick();
        inst_retired = 1'b0;
        read_at(12'hB02);
        checks++;
        if (csr_rd_data !== 32'd1) begin
            failures++; $display("FAIL minstret_retire got=%h exp=%h", csr_rd_data, 32'd1);
        end
    endtask

    task automatic test_counter_wrap();
        csr_write(12'hB00, 32'hFFFF_FFFF);
        read_at(12'hB00);
        checks++;
        if (csr_rd_data !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL mcycle_write got=%h exp=%h", csr_rd_data, 32'hFFFF_FFFF);
        end
        tick();
        read_at(12'hB00);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL mcycle_carry_lo got=%h exp=%h", csr_rd_data, 32'd0);
        end
        read_at(12'hB80);
        checks++;
        if (csr_rd_data !== 32'd1) begin
            failures++; $display("FAIL mcycle_carry_hi got=%h exp=%h", csr_rd_data, 32'd1);
        end
        // Writing the high half suppresses the increment, so the low half stays 0.
        csr_write(12'hB80, 32'hFFFF_FFFF);
        read_at(12'hB00);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL mcycleh_write_suppress got=%h exp=%h", csr_rd_data, 32'd0);
        end
        csr_write(12'hB00, 32'hFFFF_FFFF);
        tick();
        read_at(12'hB00);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL wrap64_lo got=%h exp=%h", csr_rd_data, 32'd0);
        end
        read_at(12'hB80);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL wrap64_hi got=%h exp=%h", csr_rd_data, 32'd0);
        end
        csr_write(12'hB82, 32'd7);
        read_at(12'hB82);
        checks++;
        if (csr_rd_data !== 32'd7) begin
            failures++; $display("FAIL minstreth_write got=%h exp=%h", csr_rd_data, 32'd7);
        end
        read_at(12'hB02);
        checks++;
        if (csr_rd_data !== 32'd1) begin
            failures++; $display("FAIL minstret_lo_kept got=%h exp=%h", csr_rd_data, 32'd1);
        end
    endtask

    task automatic test_illegal();
        csr_en      = 1'b1;
        csr_wr      = 1'b1;
        csr_addr    = 12'h301;
        csr_wr_data = 32'h0;
        #1;
        checks++;
        if (illegal_csr !== 1'b1) begin
            failures++; $display("FAIL illegal_misa_wr got=%b exp=1", illegal_csr);
        end
        tick();
        csr_wr = 1'b0;
        #1;
        checks++;
        if (csr_rd_data !== 32'h4000_0100 || illegal_csr !== 1'b0) begin
            failures++; $display("FAIL misa_read got=%h ill=%b exp=40000100 ill=0", csr_rd_data, illegal_csr);
        end
        csr_wr      = 1'b1;
        csr_addr    = 12'h7C0;
        csr_wr_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (illegal_csr !== 1'b1 || csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL illegal_unmapped got ill=%b rd=%h exp ill=1 rd=0", illegal_csr, csr_rd_data);
        end
        tick();
        csr_wr = 1'b0;
        csr_en = 1'b0;
        #1;
        checks++;
        if (illegal_csr !== 1'b0) begin
            failures++; $display("FAIL unmapped_no_en got=%b exp=0", illegal_csr);
        end
        read_at(12'h340);
        checks++;
        if (csr_rd_data !== 32'h1234_5678) begin
            failures++; $display("FAIL unmapped_no_clobber got=%h exp=%h", csr_rd_data, 32'h1234_5678);
        end
        read_at(12'hF14);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL mhartid got=%h exp=%h", csr_rd_data, 32'd0);
        end
        interrupt = 1'b1;
        read_at(12'h344);
        checks++;
        if (csr_rd_data !== 32'h0000_0800 || trap_taken !== 1'b0) begin
            failures++; $display("FAIL mip_meip got=%h trap=%b exp=00000800 trap=0", csr_rd_data, trap_taken);
        end
        interrupt = 1'b0;
    endtask

    task automatic test_reset_mid_trap();
        reset     = 1'b1;
        exception = 1'b1;
        exc_code  = 31'd11;
        pc        = 32'h99C;
        tick();
        reset     = 1'b0;
        exception = 1'b0;
        read_at(12'h341);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL rst_trap_mepc got=%h exp=%h", csr_rd_data, 32'd0);
        end
        read_at(12'h342);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL rst_trap_mcause got=%h exp=%h", csr_rd_data, 32'd0);
        end
        checks++;
        if (trap_vector !== 32'h0000_2000) begin
            failures++; $display("FAIL rst_trap_mtvec got=%h exp=%h", trap_vector, 32'h0000_2000);
        end
        read_at(12'h340);
        checks++;
        if (csr_rd_data !== 32'd0) begin
            failures++; $display("FAIL rst_trap_mscratch got=%h exp=%h", csr_rd_data, 32'd0);
        end
    endtask

    initial begin
        test_reset();
        test_interrupt_trap();
        test_back_to_back();
        test_mret();
        test_exception();
        test_counter_wrap();
        test_illegal();
        test_reset_mid_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
